// File: rtl/rom_arb_pkg.sv
// Shared constants and types for the two-port ROM arbiter.
// Port 0 serves instruction fetch, port 1 serves data loads.
package rom_arb_pkg;

  localparam int NUM_PORTS   = 2;
  localparam int PORT_IFETCH = 0;
  localparam int PORT_DLOAD  = 1;
  localparam int DEF_DWIDTH  = 32;

  typedef struct packed {
    logic                  valid;
    logic [DEF_DWIDTH-1:0] data;
  } rsp_t;

endpackage

// File: rtl/rom_arb_if.sv
// Request/response handshake bundle between requesters and the arbiter.
// master = fetch/load side, slave = arbiter side.
interface rom_arb_if #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 32
) ();
  import rom_arb_pkg::*;

  logic [NUM_PORTS-1:0] req_valid_i;
  logic [AWIDTH-1:0]    req_addr0_i;
  logic [AWIDTH-1:0]    req_addr1_i;
  logic [NUM_PORTS-1:0] req_ready_o;
  logic [NUM_PORTS-1:0] rsp_valid_o;
  logic [DWIDTH-1:0]    rsp_data0_o;
  logic [DWIDTH-1:0]    rsp_data1_o;
  logic [NUM_PORTS-1:0] rsp_ready_i;

  modport master (
    output req_valid_i, req_addr0_i, req_addr1_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data0_o, rsp_data1_o
  );

  modport slave (
    input  req_valid_i, req_addr0_i, req_addr1_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data0_o, rsp_data1_o
  );

endinterface

// File: rtl/rom_arb_rsp_slot.sv
// One-entry response holding register with valid/ready drain
// and a wrapping count of accepted grants.
module rom_arb_rsp_slot #(
  parameter int DWIDTH    = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 grant_i,
  input  logic [DWIDTH-1:0]    rdata_i,
  input  logic                 rsp_ready_i,
  output logic                 rsp_valid_o,
  output logic [DWIDTH-1:0]    rsp_data_o,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic                 valid_q, valid_d;
  logic [DWIDTH-1:0]    data_q, data_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // A grant refills the slot even when it is being drained this cycle.
  always_comb begin
    valid_d = grant_i | (valid_q & ~rsp_ready_i);
    data_d  = grant_i ? rdata_i : data_q;
    cnt_d   = cnt_q + CNT_WIDTH'(grant_i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_valid_o = valid_q;
  assign rsp_data_o  = data_q;
  assign cnt_o       = cnt_q;

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin sharing of one combinational ROM between the
// fetch (port 0) and load (port 1) requesters.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int AWIDTH    = 8,
  parameter int DWIDTH    = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rom_arb_if.slave             bus,
  output logic [AWIDTH-1:0]    mem_addr_o,
  input  logic [DWIDTH-1:0]    mem_rdata_i,
  output logic [CNT_WIDTH-1:0] grant_cnt0_o,
  output logic [CNT_WIDTH-1:0] grant_cnt1_o
);

  logic [NUM_PORTS-1:0] elig;
  logic [NUM_PORTS-1:0] grant;
  logic [NUM_PORTS-1:0] rsp_valid;
  logic                 last_q, last_d;

  // No grants while reset is held, so nothing is accepted then.
  always_comb begin
    elig = '0;
    if (rst_n) begin
      elig = bus.req_valid_i & (~rsp_valid | bus.rsp_ready_i);
    end
    grant = '0;
    grant[PORT_IFETCH] = elig[PORT_IFETCH] &
                         (~elig[PORT_DLOAD] | last_q);
    grant[PORT_DLOAD]  = elig[PORT_DLOAD] &
                         (~elig[PORT_IFETCH] | ~last_q);
  end

  always_comb begin
    last_d = last_q;
    unique case (1'b1)
      grant[PORT_IFETCH]: last_d = 1'b0;
      grant[PORT_DLOAD]:  last_d = 1'b1;
      default:            last_d = last_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  assign mem_addr_o = grant[PORT_DLOAD] ? bus.req_addr1_i
                                        : bus.req_addr0_i;
  assign bus.req_ready_o = grant;
  assign bus.rsp_valid_o = rsp_valid;

  rom_arb_rsp_slot #(
    .DWIDTH    (DWIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_slot0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .grant_i     (grant[PORT_IFETCH]),
    .rdata_i     (mem_rdata_i),
    .rsp_ready_i (bus.rsp_ready_i[PORT_IFETCH]),
    .rsp_valid_o (rsp_valid[PORT_IFETCH]),
    .rsp_data_o  (bus.rsp_data0_o),
    .cnt_o       (grant_cnt0_o)
  );

  rom_arb_rsp_slot #(
    .DWIDTH    (DWIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_slot1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .grant_i     (grant[PORT_DLOAD]),
    .rdata_i     (mem_rdata_i),
    .rsp_ready_i (bus.rsp_ready_i[PORT_DLOAD]),
    .rsp_valid_o (rsp_valid[PORT_DLOAD]),
    .rsp_data_o  (bus.rsp_data1_o),
    .cnt_o       (grant_cnt1_o)
  );

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: vector table plus corner sequences.
// Counters are built 4 bits wide so the wrap case is short.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic [3:0]  cnt0, cnt1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  rom_arb_if #(.AWIDTH(8), .DWIDTH(32)) bus ();

  rom_arbiter #(
    .AWIDTH    (8),
    .DWIDTH    (32),
    .CNT_WIDTH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .mem_addr_o   (mem_addr),
    .mem_rdata_i  (mem_rdata),
    .grant_cnt0_o (cnt0),
    .grant_cnt1_o (cnt1)
  );

  function automatic logic [31:0] rom(input logic [7:0] a);
    return {8'hA5, a, ~a, a ^ 8'h3C};
  endfunction

  assign mem_rdata = rom(mem_addr);

  typedef struct {
    logic [1:0]  v;
    logic [7:0]  a0;
    logic [7:0]  a1;
    logic [1:0]  rr;
    logic [1:0]  e_rdy;
    logic [7:0]  e_ma;
    logic [1:0]  e_rv;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    logic [3:0]  e_c0;
    logic [3:0]  e_c1;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [7:0] a0,
                       input logic [7:0] a1, input logic [1:0] rr);
    bus.req_valid_i = v;
    bus.req_addr0_i = a0;
    bus.req_addr1_i = a1;
    bus.rsp_ready_i = rr;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(2'b11, 8'h10, 8'h20, 2'b11);
    step();
    step();
    chk("rst_rdy", bus.req_ready_o, 2'b00);
    chk("rst_rv", bus.rsp_valid_o, 2'b00);
    chk("rst_d0", bus.rsp_data0_o, 32'h0);
    chk("rst_d1", bus.rsp_data1_o, 32'h0);
    chk("rst_c0", cnt0, 4'd0);
    chk("rst_c1", cnt1, 4'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(2'b00, 8'h00, 8'h00, 2'b00);
    step();

    tv[0]  = '{2'b11, 8'h10, 8'h20, 2'b11, 2'b01, 8'h10, 2'b00,
               32'h0, 32'h0, 4'd0, 4'd0};
    tv[1]  = '{2'b11, 8'h10, 8'h20, 2'b11, 2'b10, 8'h20, 2'b01,
               rom(8'h10), 32'h0, 4'd1, 4'd0};
    tv[2]  = '{2'b11, 8'h11, 8'h21, 2'b01, 2'b01, 8'h11, 2'b10,
               rom(8'h10), rom(8'h20), 4'd1, 4'd1};
    tv[3]  = '{2'b11, 8'h12, 8'h21, 2'b01, 2'b01, 8'h12, 2'b11,
               rom(8'h11), rom(8'h20), 4'd2, 4'd1};
    tv[4]  = '{2'b11, 8'h13, 8'h22, 2'b11, 2'b10, 8'h22, 2'b11,
               rom(8'h12), rom(8'h20), 4'd3, 4'd1};
    tv[5]  = '{2'b00, 8'h13, 8'h22, 2'b11, 2'b00, 8'h13, 2'b10,
               rom(8'h12), rom(8'h22), 4'd3, 4'd2};
    tv[6]  = '{2'b00, 8'h13, 8'h22, 2'b00, 2'b00, 8'h13, 2'b00,
               rom(8'h12), rom(8'h22), 4'd3, 4'd2};
    tv[7]  = '{2'b10, 8'h13, 8'h30, 2'b00, 2'b10, 8'h30, 2'b00,
               rom(8'h12), rom(8'h22), 4'd3, 4'd2};
    tv[8]  = '{2'b10, 8'h13, 8'h31, 2'b00, 2'b00, 8'h13, 2'b10,
               rom(8'h12), rom(8'h30), 4'd3, 4'd3};
    tv[9]  = '{2'b00, 8'h13, 8'h31, 2'b10, 2'b00, 8'h13, 2'b10,
               rom(8'h12), rom(8'h30), 4'd3, 4'd3};
    tv[10] = '{2'b00, 8'h13, 8'h31, 2'b00, 2'b00, 8'h13, 2'b00,
               rom(8'h12), rom(8'h30), 4'd3, 4'd3};
    tv[11] = '{2'b11, 8'h40, 8'h41, 2'b11, 2'b01, 8'h40, 2'b00,
               rom(8'h12), rom(8'h30), 4'd3, 4'd3};

    // Table: reset, first conflict, back-pressure, drain, idle
    do_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(tv[i].v, tv[i].a0, tv[i].a1, tv[i].rr);
      #1;
      chk($sformatf("v%0d_rdy", i), bus.req_ready_o, tv[i].e_rdy);
      chk($sformatf("v%0d_ma", i), mem_addr, tv[i].e_ma);
      chk($sformatf("v%0d_rv", i), bus.rsp_valid_o, tv[i].e_rv);
      chk($sformatf("v%0d_d0", i), bus.rsp_data0_o, tv[i].e_d0);
      chk($sformatf("v%0d_d1", i), bus.rsp_data1_o, tv[i].e_d1);
      chk($sformatf("v%0d_c0", i), cnt0, tv[i].e_c0);
      chk($sformatf("v%0d_c1", i), cnt1, tv[i].e_c1);
      step();
    end

    // Sustained conflict alternates grants
    do_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(2'b11, 8'(i), 8'(8'h80 + i), 2'b11);
      #1;
      chk($sformatf("alt%0d_rdy", i), bus.req_ready_o,
          (i % 2 == 0) ? 2'b01 : 2'b10);
      step();
    end
    drive(2'b00, 8'h00, 8'h00, 2'b11);
    #1;
    chk("alt_c0", cnt0, 4'd5);
    chk("alt_c1", cnt1, 4'd5);
    step();

    // Single-port streaming, then counter wrap at 17 grants
    do_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(2'b01, 8'(i), 8'h00, 2'b01);
      #1;
      chk($sformatf("str%0d_rdy", i), bus.req_ready_o, 2'b01);
      chk($sformatf("str%0d_ma", i), mem_addr, 8'(i));
      if (i > 0) begin
        chk($sformatf("str%0d_rv", i), bus.rsp_valid_o[0], 1'b1);
        chk($sformatf("str%0d_d0", i), bus.rsp_data0_o,
            rom(8'(i - 1)));
      end
      step();
    end
    drive(2'b00, 8'h00, 8'h00, 2'b01);
    #1;
    chk("str_last_rv", bus.rsp_valid_o[0], 1'b1);
    chk("str_last_d0", bus.rsp_data0_o, rom(8'h07));
    chk("str_c0", cnt0, 4'd8);
    for (int i = 0; i < 9; i++) begin
      drive(2'b01, 8'(8'h50 + i), 8'h00, 2'b01);
      step();
    end
    drive(2'b00, 8'h00, 8'h00, 2'b01);
    #1;
    chk("wrap_c0", cnt0, 4'd1);
    step();

    // Reset while both responses are held
    do_reset();
    rst_n = 1'b1;
    drive(2'b11, 8'h10, 8'h20, 2'b00);
    step();
    step();
    chk("hold_rv", bus.rsp_valid_o, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("midrst_rdy", bus.req_ready_o, 2'b00);
    step();
    chk("midrst_rv", bus.rsp_valid_o, 2'b00);
    chk("midrst_c0", cnt0, 4'd0);
    chk("midrst_c1", cnt1, 4'd0);
    rst_n = 1'b1;
    drive(2'b11, 8'h10, 8'h20, 2'b11);
    #1;
    chk("postrst_rdy", bus.req_ready_o, 2'b01);
    chk("postrst_ma", mem_addr, 8'h10);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
